// File: rtl/fp2int_pkg.sv
// Shared definitions for the FP32-to-integer converter: rounding-mode codes,
// FSM states, exponent bias and saturation constants.
package fp2int_pkg;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ROUND,
        ST_DONE
    } state_e;

    localparam int BIAS = 127;

    localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

    // Out-of-range values clamp toward the operand's sign.
    function automatic logic [31:0] sat_value(input logic to_signed, input logic neg);
        if (to_signed) return neg ? INT_MIN : INT_MAX;
        else           return neg ? 32'h0 : UINT_MAX;
    endfunction

endpackage

// File: rtl/fp2int_round.sv
// Combinational rounding decision from lsb, round bit, sticky and sign.
module fp2int_round
    import fp2int_pkg::*;
(
    input  logic       lsb,
    input  logic       r,
    input  logic       sticky,
    input  logic       sign,
    input  logic [2:0] r_mode,
    output logic       inc,
    output logic       inexact
);

    always_comb begin
        inexact = r || sticky;
        case (r_mode)
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign && (r || sticky);
            RM_RUP:  inc = !sign && (r || sticky);
            RM_RMM:  inc = r;
            default: inc = r && (sticky || lsb);
        endcase
    end

endmodule

// File: rtl/fp_to_int_seq.sv
// Multi-cycle FP32 -> int32/uint32 converter with an iterative right shifter.
// Define FP2INT_ASSERT_EN to compile the embedded protocol/sanity assertions.
module fp_to_int_seq
    import fp2int_pkg::*;
#(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] fp_in,
    input  logic [2:0]  r_mode,
    input  logic        is_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] int_result,
    output logic        invalid,
    output logic        inexact
);

    localparam logic [4:0] STEP     = 5'(SHIFT_STEP);
    localparam logic [7:0] EXP_LSH  = 8'(BIAS + 23);
    localparam logic [7:0] EXP_OVF  = 8'(BIAS + 32);
    localparam logic [7:0] EXP_CAP  = 8'(BIAS - 3);
    localparam int         MAX_SHIFT_CYC = (26 + SHIFT_STEP - 1) / SHIFT_STEP;

    state_e      state_q, state_d;
    logic [31:0] res_q, res_d;
    logic        inv_q, inv_d, inx_q, inx_d;
    logic [32:0] mag_q, mag_d;
    logic [4:0]  rem_q, rem_d;
    logic        rbit_q, rbit_d, stk_q, stk_d;
    logic        sign_q, sign_d, sgn_q, sgn_d, left_q, left_d;
    logic [2:0]  rm_q, rm_d;
    logic [3:0]  lsh_q, lsh_d;

    logic [7:0]  exp_in;
    logic [22:0] frac_in;
    logic        accept, in_zero, in_nan, in_special;
    logic [4:0]  amt;
    logic [32:0] out_mask, rounded;
    logic        inc, rnd_inexact, range_ok;

    assign accept     = in_valid && in_ready;
    assign exp_in     = fp_in[30:23];
    assign frac_in    = fp_in[22:0];
    assign in_zero    = (exp_in == 8'h00) && (frac_in == 23'h0);
    assign in_nan     = (exp_in == 8'hFF) && (frac_in != 23'h0);
    assign in_special = (exp_in >= EXP_OVF) || in_zero;

    assign amt      = (rem_q > STEP) ? STEP : rem_q;
    assign out_mask = (33'd1 << amt) - 33'd1;
    assign rounded  = mag_q + 33'(inc);

    fp2int_round u_round (
        .lsb     (mag_q[0]),
        .r       (rbit_q),
        .sticky  (stk_q),
        .sign    (sign_q),
        .r_mode  (rm_q),
        .inc     (inc),
        .inexact (rnd_inexact)
    );

    always_comb begin
        if (sgn_q) range_ok = sign_q ? (rounded <= {1'b0, INT_MIN}) : (rounded <= {1'b0, INT_MAX});
        else       range_ok = sign_q ? (rounded == 33'd0)           : (rounded <= {1'b0, UINT_MAX});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            res_q   <= 32'h0;
            inv_q   <= 1'b0;
            inx_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            inv_q   <= inv_d;
            inx_q   <= inx_d;
        end
    end

    always_ff @(posedge clk) begin
        mag_q  <= mag_d;
        rem_q  <= rem_d;
        rbit_q <= rbit_d;
        stk_q  <= stk_d;
        sign_q <= sign_d;
        sgn_q  <= sgn_d;
        left_q <= left_d;
        rm_q   <= rm_d;
        lsh_q  <= lsh_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = in_special ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (left_q || (rem_q <= STEP)) state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        res_d  = res_q;
        inv_d  = inv_q;
        inx_d  = inx_q;
        mag_d  = mag_q;
        rem_d  = rem_q;
        rbit_d = rbit_q;
        stk_d  = stk_q;
        sign_d = sign_q;
        sgn_d  = sgn_q;
        left_d = left_q;
        rm_d   = rm_q;
        lsh_d  = lsh_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                sign_d = fp_in[31];
                sgn_d  = is_signed;
                rm_d   = r_mode;
                rbit_d = 1'b0;
                stk_d  = 1'b0;
                mag_d  = {9'd0, |exp_in, frac_in};
                left_d = (exp_in >= EXP_LSH);
                lsh_d  = (exp_in >= EXP_LSH) ? 4'(exp_in - EXP_LSH) : 4'd0;
                if (exp_in >= EXP_LSH)     rem_d = 5'd0;
                else if (exp_in < EXP_CAP) rem_d = 5'd26;
                else                       rem_d = 5'(EXP_LSH - exp_in);
                inx_d  = 1'b0;
                if (in_nan) begin
                    res_d = is_signed ? INT_MAX : UINT_MAX;
                    inv_d = 1'b1;
                end else if (exp_in >= EXP_OVF) begin
                    res_d = sat_value(is_signed, fp_in[31]);
                    inv_d = 1'b1;
                end else begin
                    res_d = 32'h0;
                    inv_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << lsh_q;
                end else begin
                    // Round bit is the top bit of this step's window; everything older folds into sticky.
                    mag_d  = mag_q >> amt;
                    rem_d  = rem_q - amt;
                    rbit_d = |(mag_q & (out_mask & ~(out_mask >> 1)));
                    stk_d  = stk_q | rbit_q | (|(mag_q & (out_mask >> 1)));
                end
            end
            ST_ROUND: begin
                if (!range_ok) begin
                    res_d = sat_value(sgn_q, sign_q);
                    inv_d = 1'b1;
                    inx_d = 1'b0;
                end else begin
                    res_d = (sgn_q && sign_q) ? -rounded[31:0] : rounded[31:0];
                    inv_d = 1'b0;
                    inx_d = rnd_inexact;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready   = (state_q == ST_IDLE);
        out_valid  = (state_q == ST_DONE);
        int_result = res_q;
        invalid    = inv_q;
        inexact    = inx_q;
    end

`ifdef FP2INT_ASSERT_EN
    logic [4:0] shift_cyc_q, shift_cyc_d;

    assign shift_cyc_d = (state_q == ST_SHIFT) ? shift_cyc_q + 5'd1 : 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shift_cyc_q <= 5'd0;
        else        shift_cyc_q <= shift_cyc_d;
    end

    a_valid_hold: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> out_valid);
    a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid && !out_ready |=> $stable(int_result) && $stable(invalid) && $stable(inexact));
    a_ready_idle: assert property (@(posedge clk) disable iff (!rst_n)
        in_ready == (state_q == ST_IDLE));
    a_shift_len: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_SHIFT) |-> (int'(shift_cyc_q) < MAX_SHIFT_CYC));
    a_inv_inx: assert property (@(posedge clk) disable iff (!rst_n)
        invalid |-> !inexact);
`endif

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Directed and randomized bench for fp_to_int_seq against a value-level reference model.
module tb_fp_to_int_seq;

    localparam int STEP = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_in;
    logic [2:0]  r_mode;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] int_result;
    logic        invalid;
    logic        inexact;

    int n_tests = 0;
    int n_fail  = 0;

    fp_to_int_seq #(.SHIFT_STEP(STEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fp_in      (fp_in),
        .r_mode     (r_mode),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .int_result (int_result),
        .invalid    (invalid),
        .inexact    (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    // Value-level model: exact value m*2^(E-23), split into integer and fraction,
    // fraction compared against one half.
    task automatic ref_model(input logic [31:0] fp, input logic [2:0] rm, input logic sgn,
                             output logic [31:0] res, output logic inv, output logic inx,
                             output int lat);
        logic [7:0]  e;
        logic [22:0] f;
        logic        neg, nz, up, ok;
        longint      m, mag, rem, half, v;
        int          ee, sh, cnt, cmp;
        e = fp[30:23]; f = fp[22:0]; neg = fp[31];
        inv = 1'b0; inx = 1'b0; res = 32'h0; lat = 1;
        if (e == 8'hFF && f != 0) begin
            inv = 1'b1; res = sgn ? 32'h7FFF_FFFF : 32'hFFFF_FFFF; return;
        end
        if (int'(e) - 127 >= 32) begin
            inv = 1'b1;
            res = sgn ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : (neg ? 32'h0 : 32'hFFFF_FFFF);
            return;
        end
        if (e == 0 && f == 0) return;
        ee  = int'(e) - 127;
        cnt = (ee >= 23) ? 0 : ((23 - ee > 26) ? 26 : 23 - ee);
        lat = 2 + ((cnt == 0) ? 1 : (cnt + STEP - 1) / STEP);
        m   = longint'({(e != 0), f});
        if (e == 0) ee = -126;
        if (ee >= 23) begin
            mag = m << (ee - 23); nz = 1'b0; cmp = -1;
        end else begin
            sh = 23 - ee;
            if (sh > 40) begin
                mag = 0; nz = 1'b1; cmp = -1;
            end else begin
                mag  = m >> sh;
                rem  = m - (mag << sh);
                half = 64'sd1 << (sh - 1);
                nz   = (rem != 0);
                cmp  = (rem < half) ? -1 : ((rem == half) ? 0 : 1);
            end
        end
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = neg && nz;
            3'd3:    up = !neg && nz;
            3'd4:    up = (cmp >= 0);
            default: up = (cmp > 0) || (cmp == 0 && (mag % 2) == 1);
        endcase
        mag = mag + (up ? 1 : 0);
        v   = neg ? -mag : mag;
        if (sgn) ok = (v >= -64'sd2147483648) && (v <= 64'sd2147483647);
        else     ok = (v >= 0) && (v <= 64'sd4294967295);
        if (!ok) begin
            inv = 1'b1;
            res = sgn ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : (neg ? 32'h0 : 32'hFFFF_FFFF);
        end else begin
            res = v[31:0];
            inx = nz;
        end
    endtask

    // Accept one operand and wait (bounded) for out_valid; garbage is driven while busy.
    task automatic run_op(input logic [31:0] fp, input logic [2:0] rm, input logic sgn,
                          output logic [31:0] res, output logic inv, output logic inx,
                          output int lat);
        in_valid = 1'b1; fp_in = fp; r_mode = rm; is_signed = sgn;
        @(posedge clk); #1;
        in_valid  = 1'($urandom());
        fp_in     = $urandom();
        r_mode    = 3'($urandom());
        is_signed = ~sgn;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = int_result; inv = invalid; inx = inexact;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] fp, input logic [2:0] rm,
                            input logic sgn, input logic [31:0] want_res,
                            input logic want_inv, input logic want_inx);
        logic [31:0] r, mr;
        logic        iv, ix, miv, mix;
        int          lat, mlat;
        ref_model(fp, rm, sgn, mr, miv, mix, mlat);
        run_op(fp, rm, sgn, r, iv, ix, lat);
        chk({tag, "_res"}, r, want_res);
        chk({tag, "_inv"}, 32'(iv), 32'(want_inv));
        chk({tag, "_inx"}, 32'(ix), 32'(want_inx));
        chk({tag, "_lat"}, 32'(lat), 32'(mlat));
        finish_op();
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r, mr, fp;
        logic [22:0] fmask;
        logic [7:0]  e;
        logic        iv, ix, miv, mix, sg;
        logic [2:0]  rm;
        int          lat, mlat, sel;

        rst_n = 1'b0; in_valid = 1'b0; fp_in = 32'h0; r_mode = 3'd0;
        is_signed = 1'b0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", int_result, 32'h0);
        chk("rst_flags", {30'd0, invalid, inexact}, 32'd0);
        #5 rst_n = 1'b1;
        @(posedge clk); #1;

        directed("p25_rne", 32'h4020_0000, 3'd0, 1'b1, 32'd2, 1'b0, 1'b1);
        directed("p25_rmm", 32'h4020_0000, 3'd4, 1'b1, 32'd3, 1'b0, 1'b1);
        directed("p25_rup", 32'h4020_0000, 3'd3, 1'b1, 32'd3, 1'b0, 1'b1);
        directed("p25_rtz", 32'h4020_0000, 3'd1, 1'b1, 32'd2, 1'b0, 1'b1);
        directed("m15_rdn", 32'hBFC0_0000, 3'd2, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1);
        directed("m2p31_s", 32'hCF00_0000, 3'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        directed("p2p31_s", 32'h4F00_0000, 3'd0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        directed("p2p31_u", 32'h4F00_0000, 3'd0, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        directed("nan_s",   32'h7FC0_0000, 3'd0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b0);
        directed("minf_s",  32'hFF80_0000, 3'd0, 1'b1, 32'h8000_0000, 1'b1, 1'b0);
        directed("m03_rtz", 32'hBE99_999A, 3'd1, 1'b0, 32'h0, 1'b0, 1'b1);
        directed("m03_rdn", 32'hBE99_999A, 3'd2, 1'b0, 32'h0, 1'b1, 1'b0);
        directed("mzero_u", 32'h8000_0000, 3'd2, 1'b0, 32'h0, 1'b0, 1'b0);

        // 1.0: fixed latency, then back-pressure for five cycles.
        run_op(32'h3F80_0000, 3'd0, 1'b1, r, iv, ix, lat);
        chk("one_lat", 32'(lat), 32'd8);
        chk("one_res", r, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_res", k), int_result, 32'd1);
            chk($sformatf("hold%0d_vld", k), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d_rdy", k), 32'(in_ready), 32'd0);
            chk($sformatf("hold%0d_flg", k), {30'd0, invalid, inexact}, 32'd0);
        end
        finish_op();

        // Reset pulse in the middle of SHIFT drops the operation.
        in_valid = 1'b1; fp_in = 32'h3F80_0000; r_mode = 3'd0; is_signed = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_vld", 32'(out_valid), 32'd0);
        chk("midrst_rdy", 32'(in_ready), 32'd1);
        chk("midrst_res", int_result, 32'h0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        directed("post_rst", 32'hC0B0_0000, 3'd0, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      e = 8'hFF;
            else if (sel == 1) e = 8'h00;
            else               e = 8'($urandom_range(110, 160));
            fmask = 23'h7F_FFFF << $urandom_range(0, 22);
            fp = {1'($urandom()), e, 23'($urandom()) & fmask};
            rm = 3'($urandom());
            sg = 1'($urandom());
            ref_model(fp, rm, sg, mr, miv, mix, mlat);
            run_op(fp, rm, sg, r, iv, ix, lat);
            chk($sformatf("rnd%0d_%08h_res", i, fp), r, mr);
            chk($sformatf("rnd%0d_%08h_inv", i, fp), 32'(iv), 32'(miv));
            chk($sformatf("rnd%0d_%08h_inx", i, fp), 32'(ix), 32'(mix));
            chk($sformatf("rnd%0d_%08h_lat", i, fp), 32'(lat), 32'(mlat));
            finish_op();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
